// File: rtl/chess_pkg.sv
// Shared types for the move sequencer: FSM state encoding, piece codes and side helpers.
package chess_pkg;

  typedef enum logic [2:0] {
    IDLE, QUERY, CHECK, PICK, WAIT_MOVES, HOLD, PLACE, OVER
  } seq_state_t;

  localparam logic [3:0] EMPTY    = 4'h0;
  localparam logic [3:0] W_PAWN   = 4'h1;
  localparam logic [3:0] W_KNIGHT = 4'h2;
  localparam logic [3:0] W_BISHOP = 4'h3;
  localparam logic [3:0] W_ROOK   = 4'h4;
  localparam logic [3:0] W_QUEEN  = 4'h5;
  localparam logic [3:0] W_KING   = 4'h6;
  localparam logic [3:0] B_PAWN   = 4'h7;
  localparam logic [3:0] B_KNIGHT = 4'h8;
  localparam logic [3:0] B_BISHOP = 4'h9;
  localparam logic [3:0] B_ROOK   = 4'hA;
  localparam logic [3:0] B_QUEEN  = 4'hB;
  localparam logic [3:0] B_KING   = 4'hC;

  function automatic logic is_white(input logic [3:0] code);
    return (code >= W_PAWN) && (code <= W_KING);
  endfunction

  function automatic logic is_black(input logic [3:0] code);
    return (code >= B_PAWN) && (code <= B_KING);
  endfunction

endpackage

// File: rtl/chess_timer.sv
// Per-side chess clock: one-second prescaler plus two saturating down-counters of remaining seconds.
// Only the side to move is charged; the whole block freezes when run_i is low.
module chess_timer #(
  parameter int CLK_HZ       = 65_000_000,
  parameter int TIME_LIMIT_S = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic       side_i,
  output logic [9:0] white_time_o,
  output logic [9:0] black_time_o
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    wt_q, wt_d, bt_q, bt_d;
  logic          tick;

  always_comb begin
    presc_d = presc_q;
    wt_d    = wt_q;
    bt_d    = bt_q;
    tick    = 1'b0;
    if (run_i) begin
      if (presc_q == PW'(CLK_HZ - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (tick) begin
      if (!side_i) begin
        if (wt_q != '0) wt_d = wt_q - 1'b1;
      end else begin
        if (bt_q != '0) bt_d = bt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      wt_q    <= 10'(TIME_LIMIT_S);
      bt_q    <= 10'(TIME_LIMIT_S);
    end else begin
      presc_q <= presc_d;
      wt_q    <= wt_d;
      bt_q    <= bt_d;
    end
  end

  assign white_time_o = wt_q;
  assign black_time_o = bt_q;

endmodule

// File: rtl/move_sequencer.sv
// Click-driven pick/place sequencer for a chess board; chess clock compiled in with CHESS_CLOCK_EN.
// Pick 3 cycles after an IDLE click, release 1 cycle after an accepted HOLD click; other clicks dropped.
module move_sequencer
  import chess_pkg::*;
#(
  parameter int CLK_HZ        = 65_000_000,
  parameter int TIME_LIMIT_S  = 600,
  parameter int MOVES_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        click,
  input  logic [5:0]  click_pos,
  output logic [5:0]  query_pos,
  input  logic [3:0]  query_code,
  input  logic [63:0] possible_moves,
  input  logic        moves_valid,
  input  logic        white_win,
  input  logic        black_win,
  output logic        pick_place,
  output logic [5:0]  board_pos,
  output logic        turn,
  output logic        holding,
  output logic        game_over
`ifdef CHESS_CLOCK_EN
  ,
  output logic [9:0]  white_time_s,
  output logic [9:0]  black_time_s
`endif
);

  localparam int CW = $clog2(MOVES_TIMEOUT + 1);

  seq_state_t    state_q, state_d;
  logic [5:0]    src_q, src_d, dst_q, dst_d;
  logic [5:0]    board_pos_q, board_pos_d, query_pos_q, query_pos_d;
  logic [63:0]   mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick_place_q, pick_place_d;
  logic          turn_q, turn_d, holding_q, holding_d;
  logic          win_pend_q, win_pend_d;
  logic          win, own, expired;

  assign win = white_win | black_win;
  assign own = turn_q ? is_black(query_code) : is_white(query_code);

`ifdef CHESS_CLOCK_EN
  chess_timer #(
    .CLK_HZ       (CLK_HZ),
    .TIME_LIMIT_S (TIME_LIMIT_S)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .run_i        (state_q != OVER),
    .side_i       (turn_q),
    .white_time_o (white_time_s),
    .black_time_o (black_time_s)
  );
  assign expired = (white_time_s == '0) || (black_time_s == '0);
`else
  localparam int unused_cfg = CLK_HZ + TIME_LIMIT_S;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    board_pos_d  = board_pos_q;
    query_pos_d  = query_pos_q;
    pick_place_d = pick_place_q;
    turn_d       = turn_q;
    holding_d    = holding_q;
    win_pend_d   = win_pend_q;

    case (state_q)
      IDLE: begin
        if (win) begin
          state_d = OVER;
        end else if (click) begin
          src_d       = click_pos;
          query_pos_d = click_pos;
          state_d     = QUERY;
        end
      end
      QUERY: state_d = win ? OVER : CHECK;
      CHECK: begin
        if (win) begin
          state_d = OVER;
        end else if (own) begin
          board_pos_d  = src_q;
          pick_place_d = 1'b1;
          holding_d    = 1'b1;
          state_d      = PICK;
        end else begin
          state_d = IDLE;
        end
      end
      PICK: begin
        cnt_d   = '0;
        state_d = WAIT_MOVES;
      end
      WAIT_MOVES: begin
        if (moves_valid) begin
          mask_d  = possible_moves;
          state_d = HOLD;
        end else if (cnt_q == CW'(MOVES_TIMEOUT - 1)) begin
          // No legal-move answer: put the piece back where it came from.
          dst_d        = src_q;
          board_pos_d  = src_q;
          pick_place_d = 1'b0;
          holding_d    = 1'b0;
          state_d      = PLACE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (click && !moves_valid) begin
          dst_d = click_pos;
          if (mask_q[click_pos] || (click_pos == src_q)) begin
            board_pos_d  = click_pos;
            pick_place_d = 1'b0;
            holding_d    = 1'b0;
            state_d      = PLACE;
          end
        end
      end
      PLACE: begin
        turn_d     = turn_q ^ (dst_q != src_q);
        win_pend_d = 1'b0;
        state_d    = (win || win_pend_q) ? OVER : IDLE;
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase

    // A win seen while a piece is lifted is deferred until that piece is released.
    if (win && holding_q) win_pend_d = 1'b1;

    if (expired && (state_q != OVER)) begin
      state_d      = OVER;
      pick_place_d = 1'b0;
      holding_d    = 1'b0;
      board_pos_d  = holding_q ? src_q : board_pos_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      board_pos_q  <= '0;
      query_pos_q  <= '0;
      pick_place_q <= 1'b0;
      turn_q       <= 1'b0;
      holding_q    <= 1'b0;
      win_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      board_pos_q  <= board_pos_d;
      query_pos_q  <= query_pos_d;
      pick_place_q <= pick_place_d;
      turn_q       <= turn_d;
      holding_q    <= holding_d;
      win_pend_q   <= win_pend_d;
    end
  end

  // Reset releases the piece immediately so the board never sees a stale hold.
  assign pick_place = pick_place_q & ~rst;
  assign board_pos  = board_pos_q;
  assign query_pos  = query_pos_q;
  assign turn       = turn_q;
  assign holding    = holding_q;
  assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a static board model answering queries one cycle late.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        click;
  logic [5:0]  click_pos;
  logic [5:0]  query_pos;
  logic [3:0]  query_code;
  logic [63:0] possible_moves;
  logic        moves_valid;
  logic        white_win, black_win;
  logic        pick_place;
  logic [5:0]  board_pos;
  logic        turn, holding, game_over;
`ifdef CHESS_CLOCK_EN
  logic [9:0]  white_time_s, black_time_s;
  logic        rst2;
  logic [5:0]  qp2, bp2;
  logic        pp2, t2, h2, go2;
  logic [9:0]  wt2, bt2;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] board [64];

  always #5 clk = ~clk;
  always @(posedge clk) query_code <= board[query_pos];

  move_sequencer #(.MOVES_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .click(click), .click_pos(click_pos),
    .query_pos(query_pos), .query_code(query_code),
    .possible_moves(possible_moves), .moves_valid(moves_valid),
    .white_win(white_win), .black_win(black_win),
    .pick_place(pick_place), .board_pos(board_pos), .turn(turn),
    .holding(holding), .game_over(game_over)
`ifdef CHESS_CLOCK_EN
    , .white_time_s(white_time_s), .black_time_s(black_time_s)
`endif
  );

`ifdef CHESS_CLOCK_EN
  move_sequencer #(.CLK_HZ(10), .TIME_LIMIT_S(2), .MOVES_TIMEOUT(64)) dut2 (
    .clk(clk), .rst(rst2), .click(1'b0), .click_pos(6'd0),
    .query_pos(qp2), .query_code(4'd0),
    .possible_moves(64'd0), .moves_valid(1'b0),
    .white_win(1'b0), .black_win(1'b0),
    .pick_place(pp2), .board_pos(bp2), .turn(t2),
    .holding(h2), .game_over(go2),
    .white_time_s(wt2), .black_time_s(bt2)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_click(input logic [5:0] pos);
    click     = 1'b1;
    click_pos = pos;
    step();
    click     = 1'b0;
  endtask

  // Leaves the DUT in HOLD with the given mask latched.
  task automatic pick_and_hold(input logic [5:0] pos, input logic [63:0] mask);
    do_click(pos);
    step();
    step();
    step();
    possible_moves = mask;
    moves_valid    = 1'b1;
    step();
    moves_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_chk++;
    if ({pick_place, board_pos, query_pos, turn, holding, game_over} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: pp=%b bp=%0d qp=%0d turn=%b hold=%b go=%b, required all 0",
               pick_place, board_pos, query_pos, turn, holding, game_over);
    end
    rst = 1'b0;
    step();
    n_chk++;
    if (pick_place !== 1'b0 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: pp=%b go=%b, required 0 0", pick_place, game_over);
    end
  endtask

  task automatic test_move_white();
    do_click(6'd52);
    n_chk++;
    if (query_pos !== 6'd52) begin
      n_fail++; $display("FAIL white_query_pos: got %0d, required 52", query_pos);
    end
    step();
    n_chk++;
    if (pick_place !== 1'b0) begin
      n_fail++; $display("FAIL white_pick_early: pp=%b at cycle 2, required 0", pick_place);
    end
    step();
    n_chk++;
    if (pick_place !== 1'b1 || board_pos !== 6'd52 || holding !== 1'b1) begin
      n_fail++;
      $display("FAIL white_pick: pp=%b bp=%0d hold=%b at cycle 3, required 1 52 1", pick_place, board_pos, holding);
    end
    step();
    possible_moves = 64'd1 << 44;
    moves_valid    = 1'b1;
    step();
    moves_valid    = 1'b0;
    n_chk++;
    if (board_pos !== 6'd52 || pick_place !== 1'b1) begin
      n_fail++; $display("FAIL white_hold_stable: bp=%0d pp=%b, required 52 1", board_pos, pick_place);
    end
    do_click(6'd44);
    n_chk++;
    if (pick_place !== 1'b0 || board_pos !== 6'd44 || holding !== 1'b0) begin
      n_fail++;
      $display("FAIL white_place: pp=%b bp=%0d hold=%b, required 0 44 0", pick_place, board_pos, holding);
    end
    step();
    step();
    n_chk++;
    if (turn !== 1'b1 || board_pos !== 6'd44) begin
      n_fail++; $display("FAIL white_turn: turn=%b bp=%0d, required 1 44", turn, board_pos);
    end
  endtask

  task automatic test_black_move();
    pick_and_hold(6'd12, 64'd1 << 20);
    n_chk++;
    if (holding !== 1'b1 || board_pos !== 6'd12) begin
      n_fail++; $display("FAIL black_pick: hold=%b bp=%0d, required 1 12", holding, board_pos);
    end
    do_click(6'd20);
    n_chk++;
    if (pick_place !== 1'b0 || board_pos !== 6'd20) begin
      n_fail++; $display("FAIL black_place: pp=%b bp=%0d, required 0 20", pick_place, board_pos);
    end
    step();
    step();
    n_chk++;
    if (turn !== 1'b0) begin
      n_fail++; $display("FAIL black_turn: turn=%b, required 0", turn);
    end
  endtask

  task automatic test_wrong_side();
    logic seen;
    seen = 1'b0;
    do_click(6'd12);
    for (int i = 0; i < 6; i++) begin
      if (pick_place !== 1'b0 || holding !== 1'b0) seen = 1'b1;
      step();
    end
    n_chk++;
    if (seen !== 1'b0 || turn !== 1'b0) begin
      n_fail++; $display("FAIL wrong_side: lifted=%b turn=%b, required 0 0", seen, turn);
    end
  endtask

  task automatic test_illegal_dest();
    pick_and_hold(6'd52, 64'd1 << 44);
    n_chk++;
    if (holding !== 1'b1) begin
      n_fail++; $display("FAIL illegal_pick: hold=%b, required 1", holding);
    end
    do_click(6'd36);
    step();
    n_chk++;
    if (holding !== 1'b1 || pick_place !== 1'b1 || board_pos !== 6'd52) begin
      n_fail++;
      $display("FAIL illegal_ignored: hold=%b pp=%b bp=%0d, required 1 1 52", holding, pick_place, board_pos);
    end
    do_click(6'd52);
    step();
    step();
    n_chk++;
    if (pick_place !== 1'b0 || board_pos !== 6'd52 || turn !== 1'b0) begin
      n_fail++; $display("FAIL putback: pp=%b bp=%0d turn=%b, required 0 52 0", pick_place, board_pos, turn);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_click(6'd52);
    step();
    step();
    n = 0;
    while (pick_place === 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_chk++;
    if (n != 65) begin
      n_fail++; $display("FAIL timeout_cycles: released after %0d cycles from pick, required 65", n);
    end
    step();
    step();
    n_chk++;
    if (pick_place !== 1'b0 || board_pos !== 6'd52 || turn !== 1'b0) begin
      n_fail++; $display("FAIL timeout_cancel: pp=%b bp=%0d turn=%b, required 0 52 0", pick_place, board_pos, turn);
    end
  endtask

  task automatic test_drop_clicks();
    do_click(6'd52);
    click_pos = 6'd12;
    click = 1'b1;
    step();
    click = 1'b0;
    step();
    n_chk++;
    if (pick_place !== 1'b1 || board_pos !== 6'd52) begin
      n_fail++; $display("FAIL query_click_drop: pp=%b bp=%0d, required 1 52", pick_place, board_pos);
    end
    step();
    possible_moves = 64'd1 << 44;
    moves_valid    = 1'b1;
    step();
    click_pos   = 6'd44;
    click       = 1'b1;
    step();
    click       = 1'b0;
    moves_valid = 1'b0;
    step();
    n_chk++;
    if (holding !== 1'b1 || board_pos !== 6'd52) begin
      n_fail++; $display("FAIL valid_click_drop: hold=%b bp=%0d, required 1 52", holding, board_pos);
    end
    do_click(6'd52);
    step();
    step();
    n_chk++;
    if (holding !== 1'b0 || turn !== 1'b0) begin
      n_fail++; $display("FAIL drop_putback: hold=%b turn=%b, required 0 0", holding, turn);
    end
  endtask

  task automatic test_win();
    logic seen;
    pick_and_hold(6'd52, 64'd1 << 44);
    do_click(6'd44);
    white_win = 1'b1;
    step();
    white_win = 1'b0;
    n_chk++;
    if (game_over !== 1'b1 || turn !== 1'b1) begin
      n_fail++; $display("FAIL win_over: go=%b turn=%b, required 1 1", game_over, turn);
    end
    seen = 1'b0;
    do_click(6'd12);
    for (int i = 0; i < 6; i++) begin
      if (pick_place !== 1'b0 || game_over !== 1'b1) seen = 1'b1;
      step();
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL over_click_ignored: activity=%b, required 0", seen);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_chk++;
    if (game_over !== 1'b0 || turn !== 1'b0 || board_pos !== 6'd0) begin
      n_fail++; $display("FAIL win_reset: go=%b turn=%b bp=%0d, required 0 0 0", game_over, turn, board_pos);
    end
  endtask

  task automatic test_reset_holding();
    pick_and_hold(6'd52, 64'd1 << 44);
    rst = 1'b1;
    #1;
    n_chk++;
    if (pick_place !== 1'b0) begin
      n_fail++; $display("FAIL rst_drop_now: pp=%b right after rst, required 0", pick_place);
    end
    step();
    rst = 1'b0;
    step();
    n_chk++;
    if (holding !== 1'b0 || pick_place !== 1'b0 || board_pos !== 6'd0) begin
      n_fail++; $display("FAIL rst_holding: hold=%b pp=%b bp=%0d, required 0 0 0", holding, pick_place, board_pos);
    end
  endtask

`ifdef CHESS_CLOCK_EN
  task automatic test_chess_clock();
    int n;
    rst2 = 1'b1;
    step();
    step();
    n_chk++;
    if (wt2 !== 10'd2 || bt2 !== 10'd2) begin
      n_fail++; $display("FAIL clock_reset: w=%0d b=%0d, required 2 2", wt2, bt2);
    end
    rst2 = 1'b0;
    n = 0;
    while (wt2 !== 10'd0 && n < 100) begin
      step();
      n++;
    end
    n_chk++;
    if (n != 20) begin
      n_fail++; $display("FAIL clock_expire: white hit 0 after %0d cycles, required 20", n);
    end
    step();
    n_chk++;
    if (go2 !== 1'b1 || bt2 !== 10'd2) begin
      n_fail++; $display("FAIL clock_over: go=%b b=%0d, required 1 2", go2, bt2);
    end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    click          = 1'b0;
    click_pos      = 6'd0;
    possible_moves = 64'd0;
    moves_valid    = 1'b0;
    white_win      = 1'b0;
    black_win      = 1'b0;
`ifdef CHESS_CLOCK_EN
    rst2           = 1'b1;
`endif
    for (int i = 0; i < 64; i++) board[i] = 4'h0;
    board[52] = 4'h1;
    board[12] = 4'h7;

    test_reset();
    test_move_white();
    test_black_move();
    test_wrong_side();
    test_illegal_dest();
    test_timeout();
    test_drop_clicks();
    test_win();
    test_reset_holding();
`ifdef CHESS_CLOCK_EN
    test_chess_clock();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter CLK_HZ, 65_000_000, clk frequency in Hz, used by the chess clock.
REQ-002 Parameter TIME_LIMIT_S, 600, per-player time budget in seconds.
REQ-003 Parameter MOVES_TIMEOUT, 64, maximum cycles to wait for moves_valid.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 click  in  1  one-cycle pulse, left mouse button press.
REQ-007 click_pos  in  6  square under cursor at the click: [5:3] row, [2:0] column.
REQ-008 query_pos  out  6  square address sent to the board query port.
REQ-009 query_code  in  4  piece code at query_pos, valid 1 cycle after query_pos changes.
REQ-010 possible_moves  in  64  legal-destination mask for the picked piece.
REQ-011 moves_valid  in  1  pulse: possible_moves is valid.
REQ-012 white_win, black_win  in  1 each  win flags from the board.
REQ-013 pick_place  out  1  level to the board: 1 = hold piece, 0 = release.
REQ-014 board_pos  out  6  square presented to the board with pick_place.
REQ-015 turn  out  1  side to move: 0 = white, 1 = black.
REQ-016 holding  out  1  a piece is currently lifted.
REQ-017 game_over  out  1  game has ended; all clicks are ignored.
REQ-018 white_time_s, black_time_s  out  10 each  remaining seconds (macro only).

Function
REQ-019 The FSM SHALL have the states IDLE, QUERY, CHECK, PICK, WAIT_MOVES, HOLD, PLACE and OVER.
- IDLE: on click, latch click_pos into src and go to QUERY.
- QUERY: drive query_pos=src for 1 cycle, then go to CHECK.
- CHECK: own piece = codes 1..6 when turn=0, or 7..C when turn=1. On an own piece, go to PICK; otherwise go back to IDLE with no board action.
- PICK: set board_pos=src and pick_place=1, set holding=1, then go to WAIT_MOVES.
- WAIT_MOVES: on moves_valid, latch possible_moves into mask and go to HOLD.
- HOLD: on click, latch click_pos into dst.
  - If mask[dst]=1 or dst==src, go to PLACE.
  - Otherwise, ignore the click and stay in HOLD.
- PLACE: set board_pos=dst, pick_place=0 and holding=0.
  - If dst!=src, toggle turn.
  - Go to OVER if white_win or black_win is sampled the next cycle; otherwise go to IDLE.
- OVER: set game_over=1 and hold until rst.
REQ-020 If moves_valid does not arrive within MOVES_TIMEOUT cycles in WAIT_MOVES, the block SHALL place the piece back at src (cancel) and SHALL NOT toggle turn.
REQ-021 board_pos SHALL stay stable from PICK until the following PLACE, and SHALL hold its value after PLACE.
REQ-022 Latency from click to pick_place rising SHALL be exactly 3 cycles: QUERY, CHECK, PICK.
REQ-023 Latency from the HOLD click to pick_place falling SHALL be exactly 1 cycle.
REQ-024 A click in any state other than IDLE or HOLD SHALL be dropped.
REQ-025 A click in the same cycle as moves_valid SHALL be dropped.
REQ-026 If a win flag asserts in any state, the FSM SHALL go to OVER after completing any pending PLACE.

Reset
REQ-027 On rst the FSM SHALL enter IDLE.
REQ-028 On rst all outputs SHALL go to: pick_place=0, board_pos=0, query_pos=0, turn=0, holding=0, game_over=0.
REQ-029 On rst the internal registers src, dst and mask SHALL clear to 0.
REQ-030 On rst both clocks SHALL load TIME_LIMIT_S.
REQ-031 rst asserted while holding=1 SHALL drop pick_place to 0 in the same cycle; the board resets concurrently.

Configuration
REQ-032 Macro CHESS_CLOCK_EN SHALL compile the chess clock in or out.
REQ-033 With CHESS_CLOCK_EN defined:
- a prescaler counting to CLK_HZ-1 SHALL decrement the time of the side to move once per second, saturating at 0;
- counting SHALL stop in OVER;
- when a side reaches 0, game_over SHALL assert next cycle and the FSM SHALL enter OVER;
- if that side is holding a piece, pick_place SHALL first drop with board_pos=src.
REQ-034 Without CHESS_CLOCK_EN:
- the white_time_s and black_time_s ports SHALL be absent;
- no prescaler logic SHALL exist.

Structure
REQ-035 Package chess_pkg SHALL hold:
- the seq_state_t enum;
- piece-code constants EMPTY=0, W_PAWN=1..W_KING=6, B_PAWN=7..B_KING=C;
- the function is_white/is_black(code).
REQ-036 The chess clock SHALL be a sub-module chess_timer (prescaler and two down-counters), instantiated only under CHESS_CLOCK_EN.

Verification
REQ-037 White turn, click 52 (code 1), moves_valid with mask bit 44 set, click 44 -> pick_place rises 3 cycles after the first click with board_pos=52; it falls with board_pos=44; turn becomes 1.
REQ-038 White turn, click 12 (code 7) -> pick_place stays 0, state returns to IDLE, turn stays 0.
REQ-039 Piece held at 52 with mask bit 36 clear: click 36 -> ignored, holding stays 1; then click 52 -> placed at 52, turn unchanged.
REQ-040 After a pick, no moves_valid for MOVES_TIMEOUT cycles -> pick_place falls with board_pos=src, turn unchanged.
REQ-041 white_win pulses during PLACE -> game_over=1; a later click produces no pick_place activity; rst clears game_over.
REQ-042 With CHESS_CLOCK_EN, CLK_HZ=10 and TIME_LIMIT_S=2, white idles -> white_time_s reaches 0 after 20 cycles, game_over=1.
